// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-master data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {IDLE, RD_WAIT} arb_state_t;

  localparam int NUM_M  = 2;
  localparam int M_CORE = 0;
  localparam int M_AUX  = 1;

endpackage

// File: rtl/dmem_arb_rr_arb2.sv
// Two-way round-robin grant with a one-bit priority pointer.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
        default: gnt = '0;
      endcase
      // Priority passes to the master that did not just win.
      if (|gnt) ptr_d = ~gnt[M_AUX];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= 1'b0;
    else      ptr_q <= ptr_d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the LSU and an auxiliary master,
// tracking one outstanding read with a response watchdog.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        m_req,
  input  logic [1:0]        m_we,
  input  logic [3:0]        m0_mask,
  input  logic [3:0]        m1_mask,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [31:0]       m1_wdata,
  output logic [1:0]        m_gnt,
  output logic [1:0]        m_rvalid,
  output logic [31:0]       m_rdata,
  output logic              mem_request,
  output logic              mem_we_re,
  output logic              mem_load,
  output logic [3:0]        mem_mask,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_valid,
  input  logic [31:0]       mem_rdata,
  output logic              err
);

  localparam logic [3:0] TMR_LAST = 4'(TIMEOUT - 1);

  arb_state_t       state_q, state_d;
  logic             owner_q, owner_d;
  logic [3:0]       tmr_q, tmr_d;
  logic             err_q, err_d;
  logic [NUM_M-1:0] req_eff;
  logic             rd_block;
  logic             win;
  logic             rd_gnt;

  // A read may only issue once the previous one has been answered this cycle.
  assign rd_block = (state_q == RD_WAIT) && !mem_valid;
  assign req_eff  = m_req & ~({NUM_M{rd_block}} & ~m_we);

  rr_arb2 u_rr (
    .clk (clk),
    .rst (rst),
    .req (req_eff),
    .en  (1'b1),
    .gnt (m_gnt)
  );

  assign win    = m_gnt[M_AUX];
  assign rd_gnt = (|m_gnt) && !m_we[win];
  assign err    = err_q;

  always_comb begin
    mem_request = 1'b0;
    mem_we_re   = 1'b0;
    mem_load    = 1'b0;
    mem_mask    = '0;
    mem_addr    = '0;
    mem_wdata   = '0;
    if (|m_gnt) begin
      mem_request = 1'b1;
      mem_we_re   = m_we[win];
      mem_load    = ~m_we[win];
      mem_mask    = win ? m1_mask  : m0_mask;
      mem_addr    = win ? m1_addr  : m0_addr;
      mem_wdata   = win ? m1_wdata : m0_wdata;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    tmr_d    = tmr_q;
    err_d    = err_q;
    m_rvalid = '0;
    m_rdata  = '0;
    case (state_q)
      IDLE: begin
        if (mem_valid) err_d = 1'b1;
        if (rd_gnt) begin
          state_d = RD_WAIT;
          owner_d = win;
          tmr_d   = '0;
        end
      end
      RD_WAIT: begin
        if (mem_valid) begin
          m_rvalid[owner_q] = 1'b1;
          m_rdata           = mem_rdata;
          if (rd_gnt) begin
            owner_d = win;
            tmr_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (tmr_q == TMR_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      tmr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      tmr_q   <= tmr_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model and a one-cycle memory stub.
module tb_dmem_arbiter;

  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        m_req;
  logic [1:0]        m_we;
  logic [3:0]        m0_mask, m1_mask;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [31:0]       m0_wdata, m1_wdata;
  logic [1:0]        m_gnt, m_rvalid;
  logic [31:0]       m_rdata;
  logic              mem_request, mem_we_re, mem_load;
  logic [3:0]        mem_mask;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_valid;
  logic [31:0]       mem_rdata;
  logic              err;

  dmem_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we),
    .m0_mask(m0_mask), .m1_mask(m1_mask), .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_wdata(m0_wdata), .m1_wdata(m1_wdata), .m_gnt(m_gnt), .m_rvalid(m_rvalid),
    .m_rdata(m_rdata), .mem_request(mem_request), .mem_we_re(mem_we_re),
    .mem_load(mem_load), .mem_mask(mem_mask), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_valid(mem_valid), .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem_arr [256];
  logic [31:0] ref_arr [256];

  bit          mdl_ptr, mdl_pend, mdl_owner, mdl_err;
  int unsigned mdl_age;
  logic [31:0] mdl_rdata;
  bit          stub_hold;

  task automatic model_reset();
    mdl_ptr = 0; mdl_pend = 0; mdl_owner = 0; mdl_err = 0; mdl_age = 0;
    mdl_rdata = '0;
  endtask

  task automatic idle_inputs();
    m_req = '0; m_we = '0; m0_mask = '0; m1_mask = '0; m0_addr = '0; m1_addr = '0;
    m0_wdata = '0; m1_wdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0; idle_inputs(); mem_valid = 1'b0; mem_rdata = '0; stub_hold = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // One clock: check outputs against the model, advance model and memory stub.
  task automatic step();
    logic [1:0]        elig, exp_gnt, exp_rv;
    bit                blocked, win, resp_now;
    bit                iss_load, iss_wr;
    logic [ADDR_W-1:0] iss_addr, w_addr;
    logic [31:0]       iss_data, w_data;
    logic [3:0]        iss_mask, w_mask;
    #1;
    resp_now = mem_valid;
    exp_rv   = (mdl_pend && resp_now) ? (mdl_owner ? 2'b10 : 2'b01) : 2'b00;
    blocked  = mdl_pend && !resp_now;
    for (int i = 0; i < 2; i++) elig[i] = m_req[i] && (m_we[i] || !blocked);
    win     = (elig == 2'b11) ? mdl_ptr : elig[1];
    exp_gnt = (elig == 2'b00) ? 2'b00 : (win ? 2'b10 : 2'b01);
    w_addr  = win ? m1_addr  : m0_addr;
    w_data  = win ? m1_wdata : m0_wdata;
    w_mask  = win ? m1_mask  : m0_mask;

    n_checks++;
    if (m_gnt !== exp_gnt) begin
      n_fail++; $display("FAIL gnt: got %b expected %b at %0t", m_gnt, exp_gnt, $time);
    end
    n_checks++;
    if (m_rvalid !== exp_rv) begin
      n_fail++; $display("FAIL rvalid: got %b expected %b at %0t", m_rvalid, exp_rv, $time);
    end
    if (exp_rv != 2'b00) begin
      n_checks++;
      if (m_rdata !== mdl_rdata) begin
        n_fail++; $display("FAIL rdata: got %h expected %h at %0t", m_rdata, mdl_rdata, $time);
      end
    end
    n_checks++;
    if (mem_request !== (exp_gnt != 2'b00)) begin
      n_fail++; $display("FAIL mem_request: got %b expected %b", mem_request, exp_gnt != 2'b00);
    end
    if (exp_gnt != 2'b00) begin
      n_checks++;
      if (mem_load !== !m_we[win] || mem_we_re !== m_we[win] || mem_addr !== w_addr) begin
        n_fail++; $display("FAIL issue: got load=%b we=%b addr=%h expected load=%b we=%b addr=%h",
                           mem_load, mem_we_re, mem_addr, !m_we[win], m_we[win], w_addr);
      end
      if (m_we[win]) begin
        n_checks++;
        if (mem_wdata !== w_data || mem_mask !== w_mask) begin
          n_fail++; $display("FAIL wmux: got %h/%b expected %h/%b", mem_wdata, mem_mask, w_data, w_mask);
        end
      end
    end else begin
      n_checks++;
      if (mem_load !== 1'b0 || mem_we_re !== 1'b0 || mem_addr !== '0) begin
        n_fail++; $display("FAIL idle_mem: got load=%b we=%b addr=%h expected zeros", mem_load, mem_we_re, mem_addr);
      end
    end
    n_checks++;
    if (err !== mdl_err) begin
      n_fail++; $display("FAIL err: got %b expected %b at %0t", err, mdl_err, $time);
    end

    iss_load = mem_request && mem_load;
    iss_wr   = mem_request && mem_we_re;
    iss_addr = mem_addr; iss_data = mem_wdata; iss_mask = mem_mask;

    @(posedge clk);
    if (exp_gnt != 2'b00) begin
      mdl_ptr = ~win;
      if (m_we[win])
        for (int b = 0; b < 4; b++)
          if (w_mask[b]) ref_arr[w_addr][b*8 +: 8] = w_data[b*8 +: 8];
    end
    if (mdl_pend) begin
      if (resp_now) mdl_pend = 0;
      else begin
        mdl_age++;
        if (mdl_age == TIMEOUT) begin mdl_pend = 0; mdl_err = 1; end
      end
    end else if (resp_now) begin
      mdl_err = 1;
    end
    if (exp_gnt != 2'b00 && !m_we[win]) begin
      mdl_pend = 1; mdl_owner = win; mdl_age = 0; mdl_rdata = ref_arr[w_addr];
    end

    #1;
    if (iss_wr)
      for (int b = 0; b < 4; b++)
        if (iss_mask[b]) mem_arr[iss_addr][b*8 +: 8] = iss_data[b*8 +: 8];
    mem_valid = iss_load && !stub_hold;
    mem_rdata = mem_valid ? mem_arr[iss_addr] : $urandom();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; idle_inputs(); mem_valid = 1'b0; model_reset();
    @(negedge clk); #1;
    n_checks++;
    if (m_gnt !== 2'b00 || m_rvalid !== 2'b00 || err !== 1'b0) begin
      n_fail++; $display("FAIL reset_out: got gnt=%b rvalid=%b err=%b expected 00/00/0", m_gnt, m_rvalid, err);
    end
    n_checks++;
    if (mem_request !== 1'b0 || mem_load !== 1'b0 || mem_we_re !== 1'b0 || mem_addr !== '0) begin
      n_fail++; $display("FAIL reset_mem: got req=%b load=%b we=%b addr=%h expected zeros",
                         mem_request, mem_load, mem_we_re, mem_addr);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single_read();
    do_reset();
    mem_arr[8'h10] = 32'hDEADBEEF; ref_arr[8'h10] = 32'hDEADBEEF;
    m_req = 2'b01; m_we = 2'b00; m0_addr = 8'h10;
    #1;
    n_checks++;
    if (m_gnt !== 2'b01 || mem_load !== 1'b1 || mem_addr !== 8'h10) begin
      n_fail++; $display("FAIL single_issue: got gnt=%b load=%b addr=%h expected 01/1/10", m_gnt, mem_load, mem_addr);
    end
    step();
    idle_inputs();
    #1;
    n_checks++;
    if (m_rvalid !== 2'b01 || m_rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL single_resp: got rvalid=%b rdata=%h expected 01/deadbeef", m_rvalid, m_rdata);
    end
    step();
  endtask

  task automatic test_contention();
    int g0, g1;
    logic [1:0] want;
    do_reset();
    g0 = 0; g1 = 0;
    m_req = 2'b11; m_we = 2'b11; m0_addr = 8'h01; m1_addr = 8'h02;
    m0_mask = 4'hF; m1_mask = 4'hF;
    for (int k = 0; k < 6; k++) begin
      m0_wdata = $urandom(); m1_wdata = $urandom();
      want = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      n_checks++;
      if (m_gnt !== want) begin
        n_fail++; $display("FAIL contention_k%0d: got %b expected %b", k, m_gnt, want);
      end
      if (m_gnt == 2'b01) g0++;
      if (m_gnt == 2'b10) g1++;
      step();
    end
    n_checks++;
    if (g0 != 3 || g1 != 3) begin
      n_fail++; $display("FAIL contention_share: got %0d/%0d expected 3/3", g0, g1);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_back_to_back();
    do_reset();
    m_req = 2'b01; m_we = 2'b00; m0_addr = 8'h03;
    step();
    m_req = 2'b10; m1_addr = 8'h04;
    #1;
    n_checks++;
    if (m_gnt !== 2'b10 || m_rvalid !== 2'b01 || m_rdata !== ref_arr[3]) begin
      n_fail++; $display("FAIL b2b_first: got gnt=%b rvalid=%b rdata=%h expected 10/01/%h",
                         m_gnt, m_rvalid, m_rdata, ref_arr[3]);
    end
    step();
    idle_inputs();
    #1;
    n_checks++;
    if (m_rvalid !== 2'b10 || m_rdata !== ref_arr[4]) begin
      n_fail++; $display("FAIL b2b_second: got rvalid=%b rdata=%h expected 10/%h", m_rvalid, m_rdata, ref_arr[4]);
    end
    step();
  endtask

  task automatic test_read_block();
    do_reset();
    stub_hold = 1;
    m_req = 2'b01; m_we = 2'b00; m0_addr = 8'h07;
    step();
    m_req = 2'b10; m1_addr = 8'h08;
    for (int k = 0; k < TIMEOUT; k++) begin
      #1;
      n_checks++;
      if (m_gnt !== 2'b00) begin
        n_fail++; $display("FAIL block_k%0d: got gnt=%b expected 00", k, m_gnt);
      end
      if (k == TIMEOUT - 1) stub_hold = 0;
      step();
    end
    #1;
    n_checks++;
    if (err !== 1'b1 || m_gnt !== 2'b10 || m_rvalid !== 2'b00) begin
      n_fail++; $display("FAIL block_timeout: got err=%b gnt=%b rvalid=%b expected 1/10/00", err, m_gnt, m_rvalid);
    end
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    m_req = 2'b01; m_we = 2'b00; m0_addr = 8'h05;
    step();
    idle_inputs();
    rst = 1'b0;
    mem_valid = 1'b1;
    #1;
    n_checks++;
    if (m_rvalid !== 2'b00 || err !== 1'b0) begin
      n_fail++; $display("FAIL midreset: got rvalid=%b err=%b expected 00/0", m_rvalid, err);
    end
    mem_valid = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step();
    step();
    mem_valid = 1'b1;
    step();
    #1;
    n_checks++;
    if (err !== 1'b1 || m_rvalid !== 2'b00) begin
      n_fail++; $display("FAIL spurious: got err=%b rvalid=%b expected 1/00", err, m_rvalid);
    end
    step();
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      m_req    = 2'($urandom());
      m_we     = 2'($urandom());
      m0_addr  = 8'($urandom_range(0, 15));
      m1_addr  = 8'($urandom_range(0, 15));
      m0_wdata = $urandom(); m1_wdata = $urandom();
      m0_mask  = 4'($urandom()); m1_mask = 4'($urandom());
      stub_hold = ($urandom_range(0, 15) == 0);
      step();
    end
    stub_hold = 0;
    idle_inputs();
    repeat (TIMEOUT + 1) step();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = $urandom();
      ref_arr[i] = mem_arr[i];
    end
    stub_hold = 0;
    test_reset();
    test_single_read();
    test_contention();
    test_back_to_back();
    test_read_block();
    test_reset_mid_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port round-robin arbiter that shares the single-ported data memory (`data_mem_top`) between the core load/store unit (port 0) and a secondary master such as a debug or DMA engine (port 1). It accepts one access per cycle, issues it directly to the memory, and tracks the single outstanding read. It routes the memory's registered `valid`/`data_out` back to the master that issued the read. It also runs a watchdog that flags lost read responses.

## Interface
Parameters:
- `ADDR_W`, default 8: memory word-address width; matches the memory address port.
- `TIMEOUT`, default 4: cycles to wait for `mem_valid` after a read issue before declaring an error (range 2–15).

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-low.
- `m_req[1:0]`, in, 2: per-master request, level; held until granted.
- `m_we[1:0]`, in, 2: 1 = write, 0 = read.
- `m0_mask`, `m1_mask`, in, 4: byte enables.
- `m0_addr`, `m1_addr`, in, ADDR_W: word address.
- `m0_wdata`, `m1_wdata`, in, 32: write data.
- `m_gnt[1:0]`, out, 2: combinational one-hot grant; the request is consumed this cycle.
- `m_rvalid[1:0]`, out, 2: registered-path read response strobe, one-hot.
- `m_rdata`, out, 32: read data, shared by both masters; qualified by `m_rvalid`.
- `mem_request`, `mem_we_re`, `mem_load`, out, 1: memory controls. `mem_load` = read issue.
- `mem_mask` (4), `mem_addr` (ADDR_W), `mem_wdata` (32), out: muxed from the granted master.
- `mem_valid`, in, 1; `mem_rdata`, in, 32: memory response.
- `err`, out, 1: sticky error (timeout or spurious `mem_valid`); cleared only by reset.

## Operation
- **Arbitration.** Round-robin over `m_req` with a 1-bit priority pointer `ptr`.
  - Only one requester: it wins.
  - Both requesting: `ptr` wins.
  - After any grant, `ptr` moves to the other master.
- **Read gating.** A grant is blocked for a read while a read is outstanding and `mem_valid` is not present this cycle. Writes are never blocked.
- **Issue.** On grant, drive the mem outputs from the winner in the same cycle: `mem_request`=1, `mem_we_re`=`m_we[w]`, `mem_load`=~`m_we[w]`. With no grant, all mem outputs are 0.
- **FSM.** States IDLE and RD_WAIT.
  - IDLE → RD_WAIT on a read grant. Latch `owner` = winner and load `tmr` = 0.
  - RD_WAIT + `mem_valid`: pulse `m_rvalid[owner]` and pass `m_rdata` = `mem_rdata`. Then go to RD_WAIT if a new read is granted this same cycle (owner updated), otherwise IDLE.
  - RD_WAIT without `mem_valid`: `tmr`++. When `tmr` = TIMEOUT-1, set `err`, go to IDLE, and issue no `m_rvalid`.
- **Spurious response.** `mem_valid` in IDLE sets `err` and is otherwise ignored.
- **Writes.** Fire-and-forget. Completion equals the grant cycle.

## Timing
- **Reset values.** `ptr`=0, state IDLE, `owner`=0, `tmr`=0, `err`=0, `m_rvalid`=0. Combinational outputs follow from these values.
- **Read latency.** Grant at cycle N → `m_rvalid` at N+1, given the memory's one-cycle `valid`.
- **Throughput.** Back-to-back reads reach one per cycle: the read at N+1 is granted in the same cycle that the response of N returns.
- **`m_rvalid` path.** Combinational from `mem_valid` and the registered `owner`/state. No extra latency.
- **Reset mid-read.** The outstanding read is discarded. No `m_rvalid` is produced after reset deassertion, even if `mem_valid` arrives. Because `err` is also reset, a late `mem_valid` in IDLE will set it; benches keep the memory in reset together with the arbiter.

## Structure
- **`dmem_arb_pkg`.** Holds `typedef enum logic {IDLE, RD_WAIT} arb_state_t`, `localparam NUM_M = 2`, and the master-index constants `M_CORE = 0` and `M_AUX = 1`.
- **`rr_arb2`.** One sub-module: the 2-way round-robin grant plus pointer register (inputs `req`, `en`; outputs `gnt`). The top level holds the FSM, watchdog, and muxes.

## Test plan
- **Single read.** Reset, memory word 0x10 = 0xDEADBEEF. `m_req`=01 read addr 0x10 → `m_gnt`=01 same cycle, `mem_load`=1, `mem_addr`=0x10. Next cycle `m_rvalid`=01, `m_rdata`=0xDEADBEEF.
- **Contention.** Both masters request writes continuously (m0 addr 1, m1 addr 2). Grants alternate 01, 10, 01, … starting with 01 after reset; 6 cycles give 3 grants each.
- **Back-to-back reads.** m0 reads addr 3, then m1 reads addr 4 on consecutive cycles → `m_rvalid`=01 at N+1 and 10 at N+2 with correct data, and no bubble.
- **Read blocking.** Memory stub withholds `mem_valid` while m1 requests a read → m1 is not granted. After TIMEOUT=4 cycles `err`=1, the FSM returns to IDLE, and m1 is granted the next cycle.
- **Reset mid-read / spurious valid.** Assert `rst` low one cycle after a read grant → `m_rvalid`=0 and `err`=0. A separate injected `mem_valid` in IDLE → `err`=1 and `m_rvalid` stays 0.
